// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-stage program counter.
//   pc_sel_e   next-PC source select
//   pc_select  fixed-priority encoder: stall > ret > call > jmp > br > seq
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEL_SEQ  = 3'd0,
    PC_SEL_BR   = 3'd1,
    PC_SEL_JMP  = 3'd2,
    PC_SEL_CALL = 3'd3,
    PC_SEL_RET  = 3'd4,
    PC_SEL_HOLD = 3'd5
  } pc_sel_e;

  // Lower-priority requests arriving in the same cycle are simply dropped.
  function automatic pc_sel_e pc_select(input logic stall, input logic ret,
                                        input logic call, input logic jmp,
                                        input logic br);
    if (stall)     return PC_SEL_HOLD;
    else if (ret)  return PC_SEL_RET;
    else if (call) return PC_SEL_CALL;
    else if (jmp)  return PC_SEL_JMP;
    else if (br)   return PC_SEL_BR;
    else           return PC_SEL_SEQ;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, clr_n    clock, synchronous active-low reset
//   stall         freeze pointer, count and contents
//   push, pop     push push_data / pop top entry (push wins if both)
//   push_data     W-bit return address
//   top           entry at top pointer (valid only when !empty)
//   empty, full   derived from the count register only
//   ovf, unf      combinational one-cycle error pulses (push when full,
//                 pop when empty)
module pc_ras #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         stall,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         ovf,
  output logic         unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_push = push && !stall;
  assign do_pop  = pop && !push && !stall;
  assign ovf     = do_push && full;
  assign unf     = do_pop && empty;
  assign top     = mem[ptr];

  // Pointer wraps, so a push into a full stack lands on the oldest entry.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (do_push) begin
      ptr <= ptr + PW'(1);
      if (!full) cnt <= cnt + CW'(1);
    end else if (do_pop && !empty) begin
      ptr <= ptr - PW'(1);
      cnt <= cnt - CW'(1);
    end
  end

  // Storage carries no reset; entries are only read once populated.
  always_ff @(posedge clk) begin
    if (clr_n && do_push) mem[ptr + PW'(1)] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with return-address stack.
//   clk, clr_n          clock, synchronous active-low reset
//   stall               hold pc and RAS, ignore all other controls
//   br_taken, br_offset PC-relative branch (signed byte offset)
//   jmp, jmp_target     absolute jump; call also uses jmp_target
//   call, ret           push pc+STEP and jump / pop into pc
//   pc                  current address (registered)
//   pc_plus             pc+STEP (link value, combinational from pc)
//   ras_empty/full      RAS occupancy flags
//   ras_err             sticky overflow/underflow, cleared only by reset
module pc_unit
  import pc_pkg::*;
#(
  parameter int             W         = 32,
  parameter int             STEP      = 4,
  parameter logic [W-1:0]   RESET_VEC = '0,
  parameter int             RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         stall,
  input  logic         br_taken,
  input  logic [W-1:0] br_offset,
  input  logic         jmp,
  input  logic         call,
  input  logic         ret,
  input  logic [W-1:0] jmp_target,
  output logic [W-1:0] pc,
  output logic [W-1:0] pc_plus,
  output logic         ras_empty,
  output logic         ras_full,
  output logic         ras_err
);

  pc_sel_e      sel;
  logic [W-1:0] pc_nxt, ras_top;
  logic         push, pop, ovf, unf;

  assign pc_plus = pc + W'(STEP);

  always_comb begin
    sel    = pc_select(stall, ret, call, jmp, br_taken);
    pc_nxt = pc_plus;
    push   = 1'b0;
    pop    = 1'b0;
    case (sel)
      PC_SEL_HOLD: pc_nxt = pc;
      PC_SEL_BR:   pc_nxt = pc + br_offset;  // modulo 2^W wrap is intended
      PC_SEL_JMP:  pc_nxt = jmp_target;
      PC_SEL_CALL: begin
        pc_nxt = jmp_target;
        push   = 1'b1;
      end
      PC_SEL_RET: begin
        // Return on an empty stack degrades to a sequential step.
        pc_nxt = ras_empty ? pc_plus : ras_top;
        pop    = 1'b1;
      end
      default:     pc_nxt = pc_plus;
    endcase
  end

  pc_ras #(.W(W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .clr_n     (clr_n),
    .stall     (stall),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ovf),
    .unf       (unf)
  );

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      pc      <= RESET_VEC;
      ras_err <= 1'b0;
    end else begin
      pc      <= pc_nxt;
      ras_err <= ras_err | ovf | unf;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors with a scoreboard queue. The driver applies
// one control vector per cycle on the falling edge and queues the expected
// post-edge state; the monitor pops and compares after each rising edge.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        clr_n, stall, br_taken, jmp, call, ret;
  logic [31:0] br_offset, jmp_target;
  logic [31:0] pc, pc_plus;
  logic        ras_empty, ras_full, ras_err;

  typedef struct {
    logic [31:0] pc;
    logic        emp;
    logic        full;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pc_unit #(.W(32), .STEP(4), .RESET_VEC(32'h100), .RAS_DEPTH(4)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .jmp        (jmp),
    .call       (call),
    .ret        (ret),
    .jmp_target (jmp_target),
    .pc         (pc),
    .pc_plus    (pc_plus),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
    .ras_err    (ras_err)
  );

  task automatic chk(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, req);
    end
  endtask

  // Monitor: one expected entry per clock.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, "pc",        pc,               e.pc);
      chk(e.name, "pc_plus",   pc_plus,          e.pc + 32'd4);
      chk(e.name, "ras_empty", {31'd0, ras_empty}, {31'd0, e.emp});
      chk(e.name, "ras_full",  {31'd0, ras_full},  {31'd0, e.full});
      chk(e.name, "ras_err",   {31'd0, ras_err},   {31'd0, e.err});
    end
  end

  task automatic drv(input logic rn, input logic st, input logic br,
                     input logic [31:0] off, input logic j, input logic c,
                     input logic r, input logic [31:0] tgt,
                     input logic [31:0] epc, input logic ee, input logic ef,
                     input logic er, input string nm);
    exp_t e;
    @(negedge clk);
    clr_n = rn; stall = st; br_taken = br; br_offset = off;
    jmp = j; call = c; ret = r; jmp_target = tgt;
    e.pc = epc; e.emp = ee; e.full = ef; e.err = er; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [31:0] epc, input logic ee, input logic ef,
                      input logic er, input string nm);
    drv(1, 0, 0, 0, 0, 0, 0, 0, epc, ee, ef, er, nm);
  endtask

  initial begin
    clr_n = 1'b0; stall = 0; br_taken = 0; jmp = 0; call = 0; ret = 0;
    br_offset = '0; jmp_target = '0;

    // 1: reset and sequential stepping
    drv(0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 1, 0, 0, "reset");
    idle(32'h104, 1, 0, 0, "seq1");
    idle(32'h108, 1, 0, 0, "seq2");
    idle(32'h10C, 1, 0, 0, "seq3");
    // 2: negative branch and address wrap
    drv(1, 0, 0, 0, 1, 0, 0, 32'h110, 32'h110, 1, 0, 0, "jmp110");
    drv(1, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 32'h108, 1, 0, 0, "br_neg8");
    drv(1, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0, "jmp_top");
    idle(32'h0, 1, 0, 0, "wrap");
    // 3: call / return pair
    drv(1, 0, 0, 0, 1, 0, 0, 32'h200, 32'h200, 1, 0, 0, "jmp200");
    drv(1, 0, 0, 0, 0, 1, 0, 32'h400, 32'h400, 0, 0, 0, "call400");
    drv(1, 0, 0, 0, 0, 0, 1, 0, 32'h204, 1, 0, 0, "ret204");
    // 4: overflow then drain, then underflow
    drv(1, 0, 0, 0, 0, 1, 0, 32'h1000, 32'h1000, 0, 0, 0, "call_a");
    drv(1, 0, 0, 0, 0, 1, 0, 32'h2000, 32'h2000, 0, 0, 0, "call_b");
    drv(1, 0, 0, 0, 0, 1, 0, 32'h3000, 32'h3000, 0, 0, 0, "call_c");
    drv(1, 0, 0, 0, 0, 1, 0, 32'h4000, 32'h4000, 0, 1, 0, "call_d");
    drv(1, 0, 0, 0, 0, 1, 0, 32'h5000, 32'h5000, 0, 1, 1, "call_ovf");
    drv(1, 0, 0, 0, 0, 0, 1, 0, 32'h4004, 0, 0, 1, "ret_1");
    drv(1, 0, 0, 0, 0, 0, 1, 0, 32'h3004, 0, 0, 1, "ret_2");
    drv(1, 0, 0, 0, 0, 0, 1, 0, 32'h2004, 0, 0, 1, "ret_3");
    drv(1, 0, 0, 0, 0, 0, 1, 0, 32'h1004, 1, 0, 1, "ret_4");
    drv(1, 0, 0, 0, 0, 0, 1, 0, 32'h1008, 1, 0, 1, "ret_unf");
    // 5: stall ignores call + branch
    drv(1, 0, 0, 0, 0, 1, 0, 32'h600, 32'h600, 0, 0, 1, "call600");
    for (int i = 0; i < 3; i++)
      drv(1, 1, 1, 32'h40, 0, 1, 0, 32'h700, 32'h600, 0, 0, 1, "stall");
    drv(1, 0, 0, 0, 0, 0, 1, 0, 32'h100C, 1, 0, 1, "ret_after_stall");
    // 6: priority and mid-sequence reset
    drv(1, 0, 0, 0, 0, 1, 0, 32'h800, 32'h800, 0, 0, 1, "call800");
    drv(1, 0, 1, 32'h40, 1, 0, 1, 32'h900, 32'h1010, 1, 0, 1, "ret_wins");
    drv(1, 0, 1, 32'h40, 1, 1, 0, 32'hA00, 32'hA00, 0, 0, 1, "call_wins");
    idle(32'hA04, 0, 0, 1, "seqA04");
    drv(0, 0, 0, 0, 0, 1, 0, 32'hB00, 32'h100, 1, 0, 0, "mid_reset");
    idle(32'h104, 1, 0, 0, "post_reset");
    drv(1, 0, 1, 32'h8, 1, 0, 0, 32'h300, 32'h300, 1, 0, 0, "jmp_wins");
    drv(1, 0, 1, 32'h10, 0, 0, 0, 0, 32'h310, 1, 0, 0, "br_pos");
    @(negedge clk);
    clr_n = 1; br_taken = 0; jmp = 0; call = 0; ret = 0; stall = 0;

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expected entries never checked, expected 0",
               sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
